// File: rtl/demux_32x1_reg_if.sv
// Write-side handshake bundle for demux_32x1_reg: lane index, data bit, valid/ready.
interface demux_32x1_reg_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_sel;
    logic       in_data;

    modport master (output in_valid, output in_sel, output in_data, input in_ready);
    modport slave  (input in_valid, input in_sel, input in_data, output in_ready);
endinterface

// File: rtl/demux_32x1_reg.sv
// Registered 1-to-32 write demux: captures (sel, data) through valid/ready, then
// commits the bit into one lane of q with a one-hot strobe and a done pulse.
module demux_32x1_reg (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_32x1_reg_if.slave       wr,
    input  logic                  hold,
    input  logic                  clr,
    output logic [31:0]           q,
    output logic [31:0]           wr_pulse,
    output logic                  wr_done,
    output logic                  any_set
);
    localparam int unsigned LANES = 32;
    localparam int unsigned SEL_W = 5;

    logic             a_vld_q, a_vld_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic             data_a_q, data_a_d;
    logic [LANES-1:0] q_q, q_d;
    logic [LANES-1:0] pulse_q, pulse_d;
    logic             done_q, done_d;

    logic             ready_c;
    logic             accept_c;
    logic             commit_c;
    logic [LANES-1:0] onehot_c;

    // Capture slot is free when empty or when its entry leaves this edge.
    assign ready_c     = !a_vld_q || !hold;
    assign accept_c    = wr.in_valid && ready_c;
    assign commit_c    = a_vld_q && !hold;
    assign onehot_c    = LANES'(1) << sel_a_q;
    assign wr.in_ready = ready_c;

    // Capture stage next state.
    always_comb begin
        a_vld_d  = a_vld_q;
        sel_a_d  = sel_a_q;
        data_a_d = data_a_q;
        if (accept_c) begin
            a_vld_d  = 1'b1;
            sel_a_d  = wr.in_sel;
            data_a_d = wr.in_data;
        end else if (commit_c) begin
            a_vld_d  = 1'b0;
        end
    end

    // Commit stage next state; a commit overrides clr on its own lane.
    always_comb begin
        q_d     = clr ? '0 : q_q;
        pulse_d = '0;
        done_d  = 1'b0;
        if (commit_c) begin
            q_d[sel_a_q] = data_a_q;
            pulse_d      = onehot_c;
            done_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q  <= 1'b0;
            sel_a_q  <= '0;
            data_a_q <= 1'b0;
            q_q      <= '0;
            pulse_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            a_vld_q  <= a_vld_d;
            sel_a_q  <= sel_a_d;
            data_a_q <= data_a_d;
            q_q      <= q_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
        end
    end

    assign q        = q_q;
    assign wr_pulse = pulse_q;
    assign wr_done  = done_q;
    assign any_set  = |q_q;
endmodule

// File: tb/tb_demux_32x1_reg.sv
// Scoreboard bench for demux_32x1_reg: a lane-array model predicts each commit,
// a monitor checks q/wr_pulse whenever wr_done is presented.
module tb_demux_32x1_reg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, clr;
    logic [31:0] q, wr_pulse;
    logic        wr_done, any_set;

    demux_32x1_reg_if wif();

    demux_32x1_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wif.slave),
        .hold     (hold),
        .clr      (clr),
        .q        (q),
        .wr_pulse (wr_pulse),
        .wr_done  (wr_done),
        .any_set  (any_set)
    );

    always #5 clk = ~clk;

    typedef struct { int sel; bit data; } wr_t;
    typedef struct { logic [31:0] q; logic [31:0] pulse; } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   lanes[32];
    wr_t  pend[$];
    exp_t sb[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] lanes_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = lanes[i];
        return v;
    endfunction

    function automatic void model_reset();
        pend.delete();
        for (int i = 0; i < 32; i++) lanes[i] = 1'b0;
    endfunction

    // One clock of stimulus plus the model's view of that edge.
    task automatic step(input bit v, input int sel, input bit d, input bit h, input bit c);
        bit   rdy, acc, com;
        wr_t  e;
        exp_t x;
        @(negedge clk);
        wif.in_valid = v;
        wif.in_sel   = 5'(sel);
        wif.in_data  = d;
        hold = h;
        clr  = c;
        #1;
        rdy = (pend.size() == 0) || !h;
        acc = v && rdy;
        com = (pend.size() != 0) && !h;
        chk("in_ready", 32'(wif.in_ready), 32'(rdy));
        if (c) for (int i = 0; i < 32; i++) lanes[i] = 1'b0;
        if (com) begin
            e = pend.pop_front();
            lanes[e.sel] = e.data;
            x.q = lanes_vec();
            for (int i = 0; i < 32; i++) x.pulse[i] = (i == e.sel);
            sb.push_back(x);
        end
        if (acc) begin
            e.sel = sel;
            e.data = d;
            pend.push_back(e);
        end
        @(posedge clk);
        #2;
        chk("q", q, lanes_vec());
        chk("any_set", 32'(any_set), 32'(lanes_vec() != 0));
        chk("wr_done", 32'(wr_done), 32'(com));
    endtask

    // Monitor: every presented commit must match the oldest predicted one.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) continue;
            if (wr_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 32'(wr_done), 32'd0);
                end else begin
                    x = sb.pop_front();
                    chk("mon_q", q, x.q);
                    chk("mon_wr_pulse", wr_pulse, x.pulse);
                end
            end else begin
                chk("idle_wr_pulse", wr_pulse, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q"}, q, 32'd0);
        chk({tag, "_wr_pulse"}, wr_pulse, 32'd0);
        chk({tag, "_wr_done"}, 32'(wr_done), 32'd0);
        chk({tag, "_in_ready"}, 32'(wif.in_ready), 32'd1);
        chk({tag, "_any_set"}, 32'(any_set), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wif.in_valid = 1'b0;
        wif.in_sel = '0;
        wif.in_data = 1'b0;
        hold = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single write to lane 17, including explicit known values.
        step(1, 17, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("single_q", q, 32'h0002_0000);
        chk("single_pulse", wr_pulse, 32'h0002_0000);
        step(0, 0, 0, 0, 0);
        chk("single_pulse_gone", wr_pulse, 32'd0);

        // Streaming all lanes, then clear lane 31.
        for (int i = 0; i < 32; i++) step(1, i, 1, 0, 0);
        step(1, 31, 0, 0, 0);
        chk("stream_full", q, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 0);
        chk("stream_lane31_clear", q, 32'h7FFF_FFFF);
        chk("stream_pulse31", wr_pulse, 32'h8000_0000);

        // Hold stall with lane 4 pending.
        step(1, 3, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4, 1, 1, 0);
        step(1, 4, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Fill, then commit lane 9 together with clr, then clr alone.
        for (int i = 0; i < 32; i++) step(1, i, 1, 0, 0);
        step(1, 9, 1, 0, 0);
        chk("clr_pre_full", q, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 1);
        chk("clr_commit_q", q, 32'h0000_0200);
        step(0, 0, 0, 0, 1);
        chk("clr_alone_q", q, 32'd0);

        // Write-after-write to lane 5.
        step(1, 5, 1, 0, 0);
        step(1, 5, 0, 0, 0);
        chk("waw_first", q, 32'h0000_0020);
        step(0, 0, 0, 0, 0);
        chk("waw_second", q, 32'd0);
        chk("waw_pulse2", wr_pulse, 32'h0000_0020);
        step(0, 0, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset with a write captured but not yet committed.
        for (int i = 0; i < 4; i++) step(1, i, 1, 0, 0);
        step(1, 7, 1, 1, 0);
        step(1, 8, 1, 0, 0);
        @(negedge clk);
        wif.in_valid = 1'b0;
        hold = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("dropped_write", q, 32'd0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
